pipe_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage RISC-V core. It drives the shared `halt_type` bus and the per-register discard lines that the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) consume. It arbitrates stall requests from IF, ID and MEM against taken-branch redirects from EX. It also tracks a wrong-path fetch that is still in flight, so the fetch unit can drop the stale response.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/stall_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Global pipeline hold codes driven on halt_type
    localparam logic [1:0] HaltRun   = 2'b00;  // everything advances
    localparam logic [1:0] HaltFront = 2'b01;  // PC and IF/ID hold
    localparam logic [1:0] HaltBack  = 2'b10;  // all but MEM/WB hold
    localparam logic [1:0] HaltFull  = 2'b11;  // everything holds

    // Controller state encodings
    localparam logic [1:0] CtrlInit      = 2'b00;
    localparam logic [1:0] CtrlRun       = 2'b01;
    localparam logic [1:0] CtrlFlushWait = 2'b10;

    // Saturation ceiling of the disturbed-cycle counter
    localparam logic [15:0] CntMax = 16'hFFFF;

    // A cycle is "disturbed" when anything other than a clean advance happens
    function automatic logic is_disturbed(input logic [1:0] halt,
                                          input logic       ifid_discard,
                                          input logic       idex_discard,
                                          input logic       in_flush_wait);
        return (halt != HaltRun) | ifid_discard | idex_discard | in_flush_wait;
    endfunction

endpackage

// File: rtl/stall_counter.sv
// 16-bit saturating event counter with enable.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; sticks at the ceiling instead of wrapping.
module stall_counter
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] cnt
);

    // Count enabled cycles, holding at the ceiling; cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && (cnt != CntMax)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall arbiter: hold codes, bubble inserts, redirect, wrong-path fetch drop.
// Latency: all controls combinational from state+inputs (zero cycles); stall_cnt_o one cycle.
// Backpressure: MEM stall outranks branch redirect; EX re-presents the branch while EX/MEM holds.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_branch_taken,
    input  logic        if_fetch_busy,
    input  logic        if_resp_valid,
    output logic [1:0]  halt_type,
    output logic        IFID_discard_o,
    output logic        IDEX_discard_o,
    output logic        pc_redirect_o,
    output logic        if_drop_o,
    output logic [15:0] stall_cnt_o
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       cnt_en;

    // State register; reset forces INIT immediately so outputs fall to the reset pattern
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CtrlInit;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority arbitration and next-state selection
    always_comb begin
        state_nxt      = state;
        halt_type      = HaltRun;
        IFID_discard_o = 1'b0;
        IDEX_discard_o = 1'b0;
        pc_redirect_o  = 1'b0;
        if_drop_o      = 1'b0;
        case (state)
            CtrlInit: begin
                halt_type      = HaltFull;
                IFID_discard_o = 1'b1;
                IDEX_discard_o = 1'b1;
                state_nxt      = CtrlRun;
            end
            CtrlRun: begin
                if (mem_stall_req) begin
                    // Branch is not lost: EX/MEM holds so EX presents it again
                    halt_type = HaltBack;
                end else if (ex_branch_taken) begin
                    // Younger instructions are wrong-path, including any ID hazard
                    IFID_discard_o = 1'b1;
                    IDEX_discard_o = 1'b1;
                    pc_redirect_o  = 1'b1;
                    if (if_fetch_busy) begin
                        state_nxt = CtrlFlushWait;
                    end
                end else if (id_stall_req) begin
                    halt_type      = HaltFront;
                    IDEX_discard_o = 1'b1;
                end else if (if_stall_req) begin
                    IFID_discard_o = 1'b1;
                end
            end
            CtrlFlushWait: begin
                // Stale fetch still in flight: squash whatever it returns
                if_drop_o      = 1'b1;
                IFID_discard_o = 1'b1;
                halt_type      = mem_stall_req ? HaltBack : HaltRun;
                if (if_resp_valid) begin
                    state_nxt = CtrlRun;
                end
            end
            default: begin
                halt_type      = HaltFull;
                IFID_discard_o = 1'b1;
                IDEX_discard_o = 1'b1;
                state_nxt      = CtrlInit;
            end
        endcase
    end

    // Count every cycle where the pipeline did not simply advance
    always_comb begin
        cnt_en = is_disturbed(halt_type, IFID_discard_o, IDEX_discard_o,
                              state == CtrlFlushWait);
    end

    stall_counter u_stall_counter (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .cnt (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Latency: inputs driven on the falling edge, outputs checked 1ns later.
// Backpressure: n/a.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall_req = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        mem_stall_req = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        if_fetch_busy = 1'b0;
    logic        if_resp_valid = 1'b0;
    logic [1:0]  halt_type;
    logic        IFID_discard_o;
    logic        IDEX_discard_o;
    logic        pc_redirect_o;
    logic        if_drop_o;
    logic [15:0] stall_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .if_stall_req    (if_stall_req),
        .id_stall_req    (id_stall_req),
        .mem_stall_req   (mem_stall_req),
        .ex_branch_taken (ex_branch_taken),
        .if_fetch_busy   (if_fetch_busy),
        .if_resp_valid   (if_resp_valid),
        .halt_type       (halt_type),
        .IFID_discard_o  (IFID_discard_o),
        .IDEX_discard_o  (IDEX_discard_o),
        .pc_redirect_o   (pc_redirect_o),
        .if_drop_o       (if_drop_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    // A taken branch must never be presented while a wrong-path fetch is being dropped
    always @(posedge clk) begin
        if (rst && if_drop_o) begin
            assert (!ex_branch_taken) else $error("illegal branch during flush wait");
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check all controls and the counter so far
    task automatic step(input string tag,
                        input logic i_if, input logic i_id, input logic i_mem,
                        input logic i_br, input logic i_busy, input logic i_resp,
                        input logic [1:0] e_halt, input logic e_ifid, input logic e_idex,
                        input logic e_redir, input logic e_drop);
        @(negedge clk);
        if_stall_req    = i_if;
        id_stall_req    = i_id;
        mem_stall_req   = i_mem;
        ex_branch_taken = i_br;
        if_fetch_busy   = i_busy;
        if_resp_valid   = i_resp;
        #1;
        chk({tag, ".halt"},  {14'd0, halt_type},      {14'd0, e_halt});
        chk({tag, ".ifid"},  {15'd0, IFID_discard_o}, {15'd0, e_ifid});
        chk({tag, ".idex"},  {15'd0, IDEX_discard_o}, {15'd0, e_idex});
        chk({tag, ".redir"}, {15'd0, pc_redirect_o},  {15'd0, e_redir});
        chk({tag, ".drop"},  {15'd0, if_drop_o},      {15'd0, e_drop});
        chk({tag, ".cnt"},   stall_cnt_o,             exp_cnt);
        if ((e_halt != 2'b00) || e_ifid || e_idex || e_drop) begin
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    initial begin
        // Held in reset
        #3;
        chk("rst.halt",  {14'd0, halt_type},      16'd3);
        chk("rst.ifid",  {15'd0, IFID_discard_o}, 16'd1);
        chk("rst.idex",  {15'd0, IDEX_discard_o}, 16'd1);
        chk("rst.redir", {15'd0, pc_redirect_o},  16'd0);
        chk("rst.drop",  {15'd0, if_drop_o},      16'd0);
        chk("rst.cnt",   stall_cnt_o,             16'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        //          tag          if  id mem br busy resp halt  ifid idex redir drop
        step("init",       0, 0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
        step("run0",       0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step("idstall",    0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
        step("idclear",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step("membr1",     0, 0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0);
        step("membr2",     0, 0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0);
        step("membr3",     0, 0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0);
        step("br_after",   0, 0, 0, 1, 0, 0, 2'b00, 1, 1, 1, 0);
        step("br_nobusy",  0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step("ifstall",    1, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        step("br_id",      0, 1, 0, 1, 0, 0, 2'b00, 1, 1, 1, 0);
        step("mem_id_if",  1, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        step("id_if",      1, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
        // Branch with outstanding fetch, response two cycles later
        step("fw_c0",      0, 0, 0, 1, 1, 0, 2'b00, 1, 1, 1, 0);
        step("fw_c1",      0, 1, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1);
        step("fw_c2",      0, 0, 1, 0, 0, 1, 2'b10, 1, 0, 0, 1);
        step("fw_c3",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Reset while in flush wait aborts asynchronously
        step("fw2_c0",     0, 0, 0, 1, 1, 0, 2'b00, 1, 1, 1, 0);
        step("fw2_c1",     0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.drop", {15'd0, if_drop_o},      16'd0);
        chk("arst.halt", {14'd0, halt_type},      16'd3);
        chk("arst.idex", {15'd0, IDEX_discard_o}, 16'd1);
        chk("arst.cnt",  stall_cnt_o,             16'd0);
        if_fetch_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_cnt = 16'd0;
        step("reinit",     0, 0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0);

        // Saturation: INIT gave 1, each ID stall adds 1
        for (int i = 0; i < 65533; i++) begin
            @(negedge clk);
            id_stall_req = 1'b1;
        end
        @(negedge clk); #1;
        chk("sat.fffe", stall_cnt_o, 16'hFFFE);
        for (int i = 0; i < 70000 - 65533; i++) begin
            @(negedge clk);
            id_stall_req = 1'b1;
        end
        @(negedge clk); #1;
        chk("sat.ffff", stall_cnt_o, 16'hFFFF);
        chk("sat.halt", {14'd0, halt_type}, 16'd1);
        id_stall_req = 1'b0;
        @(negedge clk); #1;
        chk("sat.hold", stall_cnt_o, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
